bsg_mesh_router_dor_alloc: RTL and testbench
============================================

# bsg_mesh_router_dor_alloc

Parametrised dimension-ordered route computation and wormhole output allocation for one 2-D mesh router tile. The block decodes each input port's head-flit destination (XY or YX order), arbitrates every output port round-robin among requesting inputs, and holds each granted input→output path until the packet's tail flit transfers. It sits between the router's input FIFOs and the output crossbar; the crossbar consumes `sel_o` as its mux selects.

## Interface
- `x_cord_width_p`, 4: X coordinate width
- `y_cord_width_p`, 5: Y coordinate width
- `dirs_p`, 5: port count; 5 is a 2-D mesh, 3 is a 1-D X ring (P,W,E). Direction index order is P=0, W=1, E=2, N=3, S=4.
- `xy_order_p`, 1: 1 resolves X first, 0 resolves Y first
- `clk_i`, in, 1: clock
- `reset_n_i`, in, 1: reset; one clock domain, asynchronous, active-low
- `v_i`, in, dirs_p: input flit valid
- `last_i`, in, dirs_p: the flit is a tail flit; a single-flit packet has `last_i`=1 on its head
- `x_dirs_i`, in, dirs_p*x_cord_width_p: destination X per input; meaningful on head flits only
- `y_dirs_i`, in, dirs_p*y_cord_width_p: destination Y per input; meaningful on head flits only
- `my_x_i`, in, x_cord_width_p: tile X coordinate; quasi-static
- `my_y_i`, in, y_cord_width_p: tile Y coordinate; quasi-static
- `yumi_o`, out, dirs_p: flit consumed from input i this cycle
- `v_o`, out, dirs_p: output o carries a valid flit
- `ready_i`, in, dirs_p: downstream of output o accepts this cycle
- `sel_o`, out, dirs_p*dirs_p: one-hot input select per output, in slice o; all-zero when `v_o[o]`=0
- `err_o`, out, 1: sticky illegal-route flag

## Operation
- **Route decode** (combinational, per input, head flits only):
  - XY order: x≠my_x routes E if dest>my_x, W if dest<my_x. Otherwise the Y comparison routes S if dest>my_y, N if dest<my_y. Equal in both dimensions routes to P.
  - YX order swaps the dimension priority.
  - With dirs_p=3, Y is ignored.
- **Input state**, per input: HEAD or BODY(dir).
  - In HEAD, the request targets the decoded output.
  - In BODY, the request targets the locked dir regardless of the x/y fields.
  - On a transfer with `last_i`=0: HEAD→BODY(dir). A transfer with `last_i`=1 returns to HEAD.
- **Output state**, per output: IDLE or LOCKED(owner). Each output also has a round-robin pointer `rr`, dirs_p wide one-hot.
  - IDLE: the winner is the first requester at or after `rr`, scanning upward with wrap. `v_o`=1 and `sel_o`=winner.
  - The first transfer (`v_o & ready_i`) pulses `yumi_o[winner]` and sets `rr` to winner+1 mod dirs_p.
  - If `last_i`=0, the output moves to LOCKED(winner). Otherwise it stays IDLE.
  - LOCKED: only the owner is considered. `v_o`=`v_i[owner]`. A transfer with `last_i`=1 returns the output to IDLE.
- A BODY input is always the owner of its locked output, so it never loses arbitration.
- No request and no flit are lost when `ready_i`=0. `yumi_o` is 0, and state and `rr` hold.
- Simultaneous events:
  - Different outputs are independent and may transfer in the same cycle.
  - Each input targets exactly one output per cycle, so `yumi_o` is never multiply driven.

## Timing
- Request to `v_o`/`sel_o` is zero-cycle (combinational).
- `yumi_o` is combinational on `ready_i`.
- State, `rr` and `err_o` update on the rising edge of `clk_i`.
- Reset values:
  - all inputs HEAD, all outputs IDLE
  - `rr` = input 0
  - `err_o` = 0
  - with inputs idle: `v_o`=0, `sel_o`=0, `yumi_o`=0
- Reset asserted mid-packet drops every lock immediately. Upstream must flush partial packets.
- Back-to-back packets through one output have no bubble: a tail transfer in cycle t allows a new head grant in cycle t+1.

## Configuration
- `BSG_MESH_ROUTER_DOR_ERR_EN` defined: the block sets sticky `err_o` on any head request that violates dimension order. Violations are:
  - a U-turn (input d routed to output d, d≠P)
  - under XY order, an N/S input requesting W or E
  - under YX order, a W/E input requesting N or S
  
  `err_o` clears only on reset. The offending flit is still routed.
- Undefined: there is no detection logic, and `err_o` is tied 0.

## Structure
- Shared package `bsg_mesh_router_pkg` holds:
  - the direction enum (P, W, E, N, S)
  - the HEAD/BODY and IDLE/LOCKED state types
  - the route-order constants
- One sub-module, `bsg_mesh_router_rr_lock_arb`: the per-output round-robin arbiter plus lock FSM. It is instantiated dirs_p times.

## Test plan
- my=(2,2), input P head to (5,2), single-flit, `ready_i`=1 → `v_o[E]`=1, `sel_o[E]`=0b00001, `yumi_o[P]`=1 the same cycle.
- Inputs W and N both heads to (2,4), 3-flit packets, with `xy_order_p`=1 → S is granted to W first (rr from 0), stays LOCKED for 3 transfers, then N is granted in the next cycle.
- Head to (1,3) with `xy_order_p`=0 → S. With `xy_order_p`=1 → W.
- Locked 4-flit packet with `ready_i[E]` low in cycles 2–3 → `yumi_o` is held 0 and the flit is held, the path is kept, and the remaining flits complete after `ready_i` rises.
- Reset pulse while output S is LOCKED mid-packet → immediately IDLE, `rr`=0, `v_o`=0; the next head re-arbitrates normally.
- Macro defined: input E head to (5,2) with my_x=2 (U-turn to E) → `err_o`=1 from the next cycle and held. Macro undefined → `err_o` stays 0.

Source files
------------

// File: rtl/bsg_mesh_router_pkg.sv
// Shared types for the mesh router allocator: direction enum, input/output lock states,
// route-order constants and the dimension-order legality check.
package bsg_mesh_router_pkg;

  typedef enum logic [2:0] {
    DirP = 3'd0,
    DirW = 3'd1,
    DirE = 3'd2,
    DirN = 3'd3,
    DirS = 3'd4
  } dir_e;

  typedef enum logic {
    InHead,
    InBody
  } in_state_e;

  typedef enum logic {
    OutIdle,
    OutLocked
  } out_state_e;

  localparam int unsigned OrderYx = 0;
  localparam int unsigned OrderXy = 1;

  // A head leaving on a dimension already resolved earlier (or turning back) breaks DOR.
  function automatic logic dor_violation(input dir_e in_dir, input dir_e out_dir,
                                         input logic xy_order);
    logic in_x, in_y, out_x, out_y;
    in_x  = (in_dir == DirW) || (in_dir == DirE);
    in_y  = (in_dir == DirN) || (in_dir == DirS);
    out_x = (out_dir == DirW) || (out_dir == DirE);
    out_y = (out_dir == DirN) || (out_dir == DirS);
    return ((in_dir == out_dir) && (in_dir != DirP)) ||
           (xy_order ? (in_y && out_x) : (in_x && out_y));
  endfunction

endpackage

// File: rtl/bsg_mesh_router_rr_lock_arb.sv
// Per-output round-robin arbiter with wormhole lock: grants a head, then holds the owner
// until its tail transfers.
module bsg_mesh_router_rr_lock_arb
  import bsg_mesh_router_pkg::*;
#(
  parameter int unsigned dirs_p = 5
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [dirs_p-1:0] req_i,
  input  logic [dirs_p-1:0] last_i,
  input  logic              ready_i,
  output logic              v_o,
  output logic [dirs_p-1:0] sel_o,
  output logic [dirs_p-1:0] yumi_o
);

  localparam int unsigned IdxW = $clog2(dirs_p);

  out_state_e        state_q;
  logic [dirs_p-1:0] owner_q;
  logic [dirs_p-1:0] rr_q;
  logic [dirs_p-1:0] win_oh;
  logic [dirs_p-1:0] rr_nxt;
  logic [IdxW-1:0]   rr_idx;
  logic [IdxW-1:0]   idx;
  logic              found;
  logic              xfer;
  logic              sel_last;

  always_comb begin
    rr_idx = '0;
    for (int unsigned k = 0; k < dirs_p; k++) begin
      if (rr_q[k]) rr_idx = IdxW'(k);
    end
    win_oh = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < dirs_p; k++) begin
      idx = IdxW'((32'(rr_idx) + k) % dirs_p);
      if (!found && req_i[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_o    = (state_q == OutLocked) ? (owner_q & req_i) : win_oh;
    v_o      = |sel_o;
    xfer     = v_o & ready_i;
    yumi_o   = xfer ? sel_o : '0;
    sel_last = |(sel_o & last_i);
    rr_nxt   = {win_oh[dirs_p-2:0], win_oh[dirs_p-1]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= OutIdle;
      owner_q <= '0;
      rr_q    <= {{(dirs_p-1){1'b0}}, 1'b1};
    end else if (xfer) begin
      unique case (state_q)
        OutIdle: begin
          rr_q <= rr_nxt;
          if (!sel_last) begin
            state_q <= OutLocked;
            owner_q <= win_oh;
          end
        end
        OutLocked: begin
          if (sel_last) begin
            state_q <= OutIdle;
            owner_q <= '0;
          end
        end
        default: state_q <= OutIdle;
      endcase
    end
  end

endmodule

// File: rtl/bsg_mesh_router_dor_alloc.sv
// Dimension-ordered route decode and wormhole output allocation for one mesh tile.
// Define BSG_MESH_ROUTER_DOR_ERR_EN to enable the sticky illegal-route flag err_o.
module bsg_mesh_router_dor_alloc
  import bsg_mesh_router_pkg::*;
#(
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 5,
  parameter int unsigned dirs_p         = 5,
  parameter int unsigned xy_order_p     = 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [dirs_p-1:0]                  v_i,
  input  logic [dirs_p-1:0]                  last_i,
  input  logic [dirs_p*x_cord_width_p-1:0]   x_dirs_i,
  input  logic [dirs_p*y_cord_width_p-1:0]   y_dirs_i,
  input  logic [x_cord_width_p-1:0]          my_x_i,
  input  logic [y_cord_width_p-1:0]          my_y_i,
  output logic [dirs_p-1:0]                  yumi_o,
  output logic [dirs_p-1:0]                  v_o,
  input  logic [dirs_p-1:0]                  ready_i,
  output logic [dirs_p*dirs_p-1:0]           sel_o,
  output logic                               err_o
);

  dir_e              route  [dirs_p];
  dir_e              target [dirs_p];
  logic [dirs_p-1:0] in_head;
  logic [dirs_p-1:0] yumi_mat [dirs_p];

  for (genvar i = 0; i < dirs_p; i++) begin : g_in
    logic [x_cord_width_p-1:0] dx;
    logic [y_cord_width_p-1:0] dy;
    logic                      x_hit, y_hit;
    dir_e                      x_dir, y_dir;
    in_state_e                 state_q;
    dir_e                      dir_q;

    assign dx = x_dirs_i[i*x_cord_width_p +: x_cord_width_p];
    assign dy = y_dirs_i[i*y_cord_width_p +: y_cord_width_p];

    always_comb begin
      x_dir = (dx > my_x_i) ? DirE : DirW;
      y_dir = (dy > my_y_i) ? DirS : DirN;
      x_hit = (dx != my_x_i);
      // A 3-port ring has no Y links, so Y never steers the flit.
      y_hit = (dirs_p > 3) && (dy != my_y_i);
      if (xy_order_p == OrderXy) begin
        route[i] = x_hit ? x_dir : (y_hit ? y_dir : DirP);
      end else begin
        route[i] = y_hit ? y_dir : (x_hit ? x_dir : DirP);
      end
    end

    assign in_head[i] = (state_q == InHead);
    assign target[i]  = in_head[i] ? route[i] : dir_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_q <= InHead;
        dir_q   <= DirP;
      end else if (yumi_o[i]) begin
        if (last_i[i]) begin
          state_q <= InHead;
        end else begin
          state_q <= InBody;
          dir_q   <= target[i];
        end
      end
    end
  end

  for (genvar o = 0; o < dirs_p; o++) begin : g_out
    logic [dirs_p-1:0] req;

    always_comb begin
      req = '0;
      for (int unsigned i = 0; i < dirs_p; i++) begin
        req[i] = v_i[i] && (target[i] == 3'(o));
      end
    end

    bsg_mesh_router_rr_lock_arb #(
      .dirs_p(dirs_p)
    ) u_arb (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .req_i    (req),
      .last_i   (last_i),
      .ready_i  (ready_i[o]),
      .v_o      (v_o[o]),
      .sel_o    (sel_o[o*dirs_p +: dirs_p]),
      .yumi_o   (yumi_mat[o])
    );
  end

  // Each input targets one output, so at most one row contributes to any yumi bit.
  always_comb begin
    yumi_o = '0;
    for (int unsigned o = 0; o < dirs_p; o++) begin
      yumi_o = yumi_o | yumi_mat[o];
    end
  end

`ifdef BSG_MESH_ROUTER_DOR_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < dirs_p; i++) begin
      if (v_i[i] && in_head[i] &&
          dor_violation(dir_e'(3'(i)), route[i], xy_order_p == OrderXy)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_mesh_router_dor_alloc.sv
// Directed bench for bsg_mesh_router_dor_alloc; an XY and a YX instance share stimulus.
module tb_bsg_mesh_router_dor_alloc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  v, last, ready;
  logic [19:0] xd;
  logic [24:0] yd;
  logic [3:0]  my_x = 4'd2;
  logic [4:0]  my_y = 5'd2;

  logic [4:0]  yumi0, vo0, yumi1, vo1;
  logic [24:0] sel0, sel1;
  logic        err0, err1;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef BSG_MESH_ROUTER_DOR_ERR_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  always #5 clk = ~clk;

  bsg_mesh_router_dor_alloc #(
    .x_cord_width_p(4), .y_cord_width_p(5), .dirs_p(5), .xy_order_p(1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .last_i(last), .x_dirs_i(xd), .y_dirs_i(yd),
    .my_x_i(my_x), .my_y_i(my_y), .yumi_o(yumi0), .v_o(vo0), .ready_i(ready), .sel_o(sel0),
    .err_o(err0)
  );

  bsg_mesh_router_dor_alloc #(
    .x_cord_width_p(4), .y_cord_width_p(5), .dirs_p(5), .xy_order_p(0)
  ) dut_yx (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .last_i(last), .x_dirs_i(xd), .y_dirs_i(yd),
    .my_x_i(my_x), .my_y_i(my_y), .yumi_o(yumi1), .v_o(vo1), .ready_i(ready), .sel_o(sel1),
    .err_o(err1)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  function automatic logic [24:0] sel_at(input int o, input int i);
    logic [24:0] one;
    one = 25'd1;
    return one << (o * 5 + i);
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp3(input string tag, input logic [4:0] ev, input logic [24:0] es,
                      input logic [4:0] ey);
    push({tag, "_v"}, 32'(ev));
    push({tag, "_sel"}, 32'(es));
    push({tag, "_yumi"}, 32'(ey));
  endtask

  task automatic chk3();
    check(32'(vo0));
    check(32'(sel0));
    check(32'(yumi0));
  endtask

  task automatic head(input int i, input int x, input int y, input logic lst);
    v[i]          = 1'b1;
    last[i]       = lst;
    xd[i*4 +: 4]  = 4'(x);
    yd[i*5 +: 5]  = 5'(y);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    v = '0; last = '0; ready = '1; xd = '0; yd = '0;
    #3;
    exp3("reset", 5'd0, 25'd0, 5'd0); chk3();
    push("reset_err", 32'd0); check(32'(err0));

    next(); reset_n = 1'b1;
    // Same head to (1,3): XY resolves W first, YX resolves S first.
    head(0, 1, 3, 1'b1); #2;
    exp3("xy_order", 5'b00010, sel_at(1, 0), 5'b00001); chk3();
    push("yx_v", 32'h10); check(32'(vo1));
    push("yx_sel", 32'(sel_at(4, 0))); check(32'(sel1));
    push("yx_yumi", 32'h1); check(32'(yumi1));

    next(); v = '0; last = '0;
    head(0, 5, 2, 1'b1); #2;
    exp3("p_to_e", 5'b00100, sel_at(2, 0), 5'b00001); chk3();

    // W and N contend for S with 3-flit packets; rr starts at 0 so W wins.
    next(); v = '0; last = '0;
    head(1, 2, 4, 1'b0); head(3, 2, 4, 1'b0); #2;
    exp3("wn_w1", 5'b10000, sel_at(4, 1), 5'b00010); chk3();
    next(); #2;
    exp3("wn_w2", 5'b10000, sel_at(4, 1), 5'b00010); chk3();
    next(); last[1] = 1'b1; #2;
    exp3("wn_w3", 5'b10000, sel_at(4, 1), 5'b00010); chk3();
    next(); v[1] = 1'b0; last[1] = 1'b0; #2;
    exp3("wn_n1", 5'b10000, sel_at(4, 3), 5'b01000); chk3();
    next(); #2;
    exp3("wn_n2", 5'b10000, sel_at(4, 3), 5'b01000); chk3();
    next(); last[3] = 1'b1; #2;
    exp3("wn_n3", 5'b10000, sel_at(4, 3), 5'b01000); chk3();
    next(); v = '0; last = '0; #2;
    exp3("wn_idle", 5'd0, 25'd0, 5'd0); chk3();

    // 4-flit P->E packet stalled two cycles while W waits for E.
    next(); head(0, 5, 2, 1'b0); #2;
    exp3("stall_h", 5'b00100, sel_at(2, 0), 5'b00001); chk3();
    next(); ready = 5'b11011; head(1, 5, 2, 1'b1); #2;
    exp3("stall_c2", 5'b00100, sel_at(2, 0), 5'b00000); chk3();
    next(); #2;
    exp3("stall_c3", 5'b00100, sel_at(2, 0), 5'b00000); chk3();
    next(); ready = '1; #2;
    exp3("stall_f2", 5'b00100, sel_at(2, 0), 5'b00001); chk3();
    next(); #2;
    exp3("stall_f3", 5'b00100, sel_at(2, 0), 5'b00001); chk3();
    next(); last[0] = 1'b1; #2;
    exp3("stall_f4", 5'b00100, sel_at(2, 0), 5'b00001); chk3();
    next(); v[0] = 1'b0; last[0] = 1'b0; #2;
    exp3("no_bubble_w", 5'b00100, sel_at(2, 1), 5'b00010); chk3();
    next(); v = '0; last = '0; #2;
    exp3("stall_idle", 5'd0, 25'd0, 5'd0); chk3();

    // Reset while S is locked by P mid-packet.
    next(); head(0, 2, 5, 1'b0); #2;
    exp3("rst_h", 5'b10000, sel_at(4, 0), 5'b00001); chk3();
    next(); #2;
    exp3("rst_b", 5'b10000, sel_at(4, 0), 5'b00001); chk3();
    next(); reset_n = 1'b0; v = '0; last = '0; #2;
    exp3("rst_mid", 5'd0, 25'd0, 5'd0); chk3();
    next(); next(); reset_n = 1'b1;
    ready = 5'b01111; head(3, 2, 5, 1'b1); #2;
    exp3("rst_unlock", 5'b10000, sel_at(4, 3), 5'b00000); chk3();
    next(); ready = '1; head(0, 2, 5, 1'b1); #2;
    exp3("rst_rr", 5'b10000, sel_at(4, 0), 5'b00001); chk3();
    next(); v[0] = 1'b0; #2;
    exp3("rst_n", 5'b10000, sel_at(4, 3), 5'b01000); chk3();
    push("err_clean", 32'd0); check(32'(err0));

    // U-turn: input E heads back out E.
    next(); v = '0; last = '0; head(2, 5, 2, 1'b1); #2;
    exp3("uturn", 5'b00100, sel_at(2, 2), 5'b00100); chk3();
    push("err_pre", 32'd0); check(32'(err0));
    next(); v = '0; last = '0; #2;
    push("err_set", 32'(ErrExp)); check(32'(err0));
    next(); #2;
    push("err_hold", 32'(ErrExp)); check(32'(err0));
    exp3("final_idle", 5'd0, 25'd0, 5'd0); chk3();

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
